// File: rtl/fetch_pkg.sv
// Shared definitions for the UART instruction fetcher: state encoding, default
// timing parameters and the checksum helper used when FETCH_CHECKSUM_EN is defined.
package fetch_pkg;

    localparam int DEF_TIMEOUT_CYCLES = 20000;
    localparam int DEF_MAX_RETRY      = 3;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_SEND    = 4'd1;
    localparam logic [3:0] ST_WAIT_TX = 4'd2;
    localparam logic [3:0] ST_RX_HI   = 4'd3;
    localparam logic [3:0] ST_RX_LO   = 4'd4;
    localparam logic [3:0] ST_RX_CK   = 4'd5;
    localparam logic [3:0] ST_DONE    = 4'd6;
    localparam logic [3:0] ST_ERROR   = 4'd7;

    typedef enum logic [3:0] {
        IDLE    = ST_IDLE,
        SEND    = ST_SEND,
        WAIT_TX = ST_WAIT_TX,
        RX_HI   = ST_RX_HI,
        RX_LO   = ST_RX_LO,
        RX_CK   = ST_RX_CK,
        DONE    = ST_DONE,
        ERROR   = ST_ERROR
    } fetch_state_t;

    function automatic logic [7:0] fetch_checksum(input logic [7:0] hi,
                                                  input logic [7:0] lo,
                                                  input logic [7:0] addr);
        return hi ^ lo ^ addr;
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Per-byte timeout counter: cleared by the fetcher on every state change,
// counts only while a wait stage is active and the UART is not lent out.
module fetch_timeout_ctr
    import fetch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Gated by enable so a frozen count (hold=1) can never fire a retry.
    assign o_expired = i_enable && (r_count == LAST);

endmodule

// File: rtl/uart_instr_fetcher.sv
// Fetches a 16-bit instruction over the shared UART (address out, hi/lo bytes in)
// with per-byte timeout, bounded retry and hold; FETCH_CHECKSUM_EN adds a checksum byte.
module uart_instr_fetcher
    import fetch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int MAX_RETRY      = DEF_MAX_RETRY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        hold,
    input  logic [7:0]  address,
    input  logic        tx_done,
    input  logic        rx_done,
    input  logic [7:0]  rx_data,
    output logic        tx_start_out,
    output logic [7:0]  tx_data_out,
    output logic [15:0] instruction_out,
    output logic        done_out,
    output logic        busy_out,
    output logic        error_out,
    output logic [3:0]  dbg_state_out
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

    fetch_state_t  r_state, w_next;
    logic [7:0]    r_addr, r_hi, r_lo;
    logic [15:0]   r_instr;
    logic [RW-1:0] r_retry;
    logic          w_accept, w_rx_ok, w_timed, w_expired, w_fail, w_tmr_clear;
    logic [7:0]    w_lo;

    // Handshake: start, tx_done and rx_done are single-cycle pulses with no
    // back-pressure; start and rx bytes are only taken when hold=0.
    assign w_accept    = start && !hold;
    assign w_rx_ok     = rx_done && !hold;
    assign w_timed     = (r_state == WAIT_TX) || (r_state == RX_HI) ||
                         (r_state == RX_LO)   || (r_state == RX_CK);
    assign w_tmr_clear = (w_next != r_state);
    assign w_lo        = (r_state == RX_LO) ? rx_data : r_lo;

    fetch_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_tmr_clear),
        .i_enable  (w_timed && !hold),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next = r_state;
        w_fail = 1'b0;
        case (r_state)
            IDLE, ERROR: if (w_accept) w_next = SEND;
            SEND:        w_next = WAIT_TX;
            WAIT_TX: begin
                if (tx_done)        w_next = RX_HI;
                else if (w_expired) w_fail = 1'b1;
            end
            RX_HI: begin
                if (w_rx_ok)        w_next = RX_LO;
                else if (w_expired) w_fail = 1'b1;
            end
            RX_LO: begin
`ifdef FETCH_CHECKSUM_EN
                if (w_rx_ok)        w_next = RX_CK;
`else
                if (w_rx_ok)        w_next = DONE;
`endif
                else if (w_expired) w_fail = 1'b1;
            end
`ifdef FETCH_CHECKSUM_EN
            RX_CK: begin
                // A wrong checksum is handled exactly like a missed byte.
                if (w_rx_ok) begin
                    if (rx_data == fetch_checksum(r_hi, r_lo, r_addr)) w_next = DONE;
                    else                                               w_fail = 1'b1;
                end else if (w_expired) begin
                    w_fail = 1'b1;
                end
            end
`endif
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (w_fail) w_next = (r_retry == RETRY_LAST) ? ERROR : SEND;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_instr <= '0;
            r_retry <= '0;
        end else begin
            r_state <= w_next;
            if (w_next == SEND) begin
                if (r_state == IDLE || r_state == ERROR) begin
                    r_addr  <= address;
                    r_retry <= '0;
                end else begin
                    r_retry <= r_retry + 1'b1;
                end
                r_hi <= '0;
                r_lo <= '0;
            end
            if (r_state == RX_HI && w_rx_ok) r_hi <= rx_data;
            if (r_state == RX_LO && w_rx_ok) r_lo <= rx_data;
            // Loaded on DONE entry so the data is valid alongside done_out.
            if (w_next == DONE && r_state != DONE) r_instr <= {r_hi, w_lo};
        end
    end

    assign tx_start_out    = (r_state == SEND);
    assign tx_data_out     = r_addr;
    assign instruction_out = r_instr;
    assign done_out        = (r_state == DONE);
    assign busy_out        = (r_state != IDLE) && (r_state != ERROR);
    assign error_out       = (r_state == ERROR);
    assign dbg_state_out   = r_state;

endmodule

// File: tb/tb_uart_instr_fetcher.sv
// Self-checking bench for uart_instr_fetcher with TIMEOUT_CYCLES=16, MAX_RETRY=2;
// honours FETCH_CHECKSUM_EN by appending the checksum byte to every response.
module tb_uart_instr_fetcher;

    localparam int TO = 16;
    localparam int MR = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        hold = 1'b0;
    logic [7:0]  address = 8'h00;
    logic        tx_done = 1'b0;
    logic        rx_done = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_start_out;
    logic [7:0]  tx_data_out;
    logic [15:0] instruction_out;
    logic        done_out;
    logic        busy_out;
    logic        error_out;
    logic [3:0]  dbg_state_out;

    int n_cmp = 0;
    int n_fail = 0;
    int n_tx = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_instr = 16'h0000;

    uart_instr_fetcher #(
        .TIMEOUT_CYCLES(TO),
        .MAX_RETRY(MR)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .hold            (hold),
        .address         (address),
        .tx_done         (tx_done),
        .rx_done         (rx_done),
        .rx_data         (rx_data),
        .tx_start_out    (tx_start_out),
        .tx_data_out     (tx_data_out),
        .instruction_out (instruction_out),
        .done_out        (done_out),
        .busy_out        (busy_out),
        .error_out       (error_out),
        .dbg_state_out   (dbg_state_out)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset && tx_start_out === 1'b1) n_tx++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    // driver tasks
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic accept(input logic [7:0] a);
        address = a;
        start = 1'b1;
        tick();
        start = 1'b0;
        address = 8'($urandom);
    endtask

    task automatic wait_tx_start();
        int k;
        k = 0;
        while (tx_start_out !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
    endtask

    task automatic respond_tx(input int d);
        repeat (d) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic respond_byte(input int d, input logic [7:0] b);
        repeat (d) tick();
        rx_done = 1'b1;
        rx_data = b;
        tick();
        rx_done = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic respond_ck(input logic [7:0] a, input logic [7:0] hi, input logic [7:0] lo);
`ifdef FETCH_CHECKSUM_EN
        respond_byte($urandom_range(0, 4), hi ^ lo ^ a);
`else
        if (a == 8'h00 && hi == 8'h00 && lo == 8'h00) tick();
`endif
    endtask

    task automatic finish_fetch(input string tag);
        int k;
        logic [15:0] e;
        k = 0;
        while (done_out !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        e = 16'h0000;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check({tag, "_done"}, done_out, 1);
        check({tag, "_instr"}, instruction_out, e);
        exp_instr = e;
        tick();
        check({tag, "_done_1cyc"}, done_out, 0);
        check({tag, "_idle"}, busy_out, 0);
    endtask

    task automatic fetch(input logic [7:0] a, input logic [7:0] hi, input logic [7:0] lo,
                         input string tag);
        int n0;
        n0 = n_tx;
        exp_q.push_back({hi, lo});
        accept(a);
        wait_tx_start();
        check({tag, "_tx_start"}, tx_start_out, 1);
        check({tag, "_tx_data"}, tx_data_out, a);
        check({tag, "_err_clear"}, error_out, 0);
        tick();
        respond_tx($urandom_range(0, 4));
        respond_byte($urandom_range(0, 4), hi);
        respond_byte($urandom_range(0, 4), lo);
        respond_ck(a, hi, lo);
        finish_fetch(tag);
        check({tag, "_tx_count"}, n_tx - n0, 1);
    endtask

    initial begin
        int n0;
        int k;
        logic [7:0] a, hi, lo;

        // reset state
        repeat (3) tick();
        check("rst_tx_start", tx_start_out, 0);
        check("rst_tx_data", tx_data_out, 0);
        check("rst_instr", instruction_out, 0);
        check("rst_done", done_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_error", error_out, 0);
        reset = 1'b1;
        tick();

        // nominal and randomized fetches
        fetch(8'h05, 8'hA1, 8'h23, "nominal");
        for (int i = 0; i < 4; i++) fetch(8'($urandom), 8'($urandom), 8'($urandom), "rand");

        // hold in IDLE blocks start; stray rx_done in IDLE is ignored
        n0 = n_tx;
        hold = 1'b1;
        accept(8'h77);
        repeat (3) tick();
        check("hold_idle_busy", busy_out, 0);
        check("hold_idle_tx", n_tx - n0, 0);
        hold = 1'b0;
        respond_byte(0, 8'hEE);
        repeat (2) tick();
        check("rx_idle_busy", busy_out, 0);
        check("rx_idle_instr", instruction_out, exp_instr);

        // start while busy and a stray rx byte in WAIT_TX are ignored
        a = 8'($urandom); hi = 8'($urandom); lo = 8'($urandom);
        n0 = n_tx;
        exp_q.push_back({hi, lo});
        accept(a);
        wait_tx_start();
        tick();
        start = 1'b1;
        address = ~a;
        tick();
        start = 1'b0;
        respond_byte(0, 8'h5A);
        respond_tx(1);
        respond_byte(2, hi);
        respond_byte(1, lo);
        respond_ck(a, hi, lo);
        finish_fetch("busy_start");
        check("busy_start_tx_count", n_tx - n0, 1);
        check("busy_start_tx_data", tx_data_out, a);

        // timeout in RX_HI, then byte on the last allowed cycle of the retry
        a = 8'($urandom); hi = 8'($urandom); lo = 8'($urandom);
        n0 = n_tx;
        exp_q.push_back({hi, lo});
        accept(a);
        wait_tx_start();
        tick();
        respond_tx(1);
        k = 0;
        while (tx_start_out !== 1'b1 && k < 60) begin
            tick();
            k++;
        end
        check("retry_gap", k, TO);
        check("retry_tx_data", tx_data_out, a);
        check("retry_instr_held", instruction_out, exp_instr);
        tick();
        respond_tx(0);
        respond_byte(TO - 1, hi);
        respond_byte(2, lo);
        respond_ck(a, hi, lo);
        finish_fetch("retry");
        check("retry_tx_count", n_tx - n0, 2);
        check("retry_error", error_out, 0);

        // retries exhausted
        n0 = n_tx;
        accept(8'($urandom));
        k = 0;
        while (error_out !== 1'b1 && k < 300) begin
            tick();
            k++;
        end
        check("exhaust_error", error_out, 1);
        check("exhaust_tx_count", n_tx - n0, MR + 1);
        check("exhaust_busy", busy_out, 0);
        check("exhaust_instr", instruction_out, exp_instr);
        repeat (5) tick();
        check("exhaust_sticky", error_out, 1);
        fetch(8'($urandom), 8'($urandom), 8'($urandom), "after_err");

        // hold mid-transfer with a stray byte
        a = 8'($urandom); hi = 8'($urandom); lo = 8'($urandom);
        n0 = n_tx;
        exp_q.push_back({hi, lo});
        accept(a);
        wait_tx_start();
        tick();
        respond_tx(0);
        respond_byte(1, hi);
        hold = 1'b1;
        repeat (20) tick();
        rx_done = 1'b1;
        rx_data = 8'hFF;
        tick();
        rx_done = 1'b0;
        repeat (29) tick();
        check("hold_busy", busy_out, 1);
        check("hold_no_retry", n_tx - n0, 1);
        check("hold_no_done", done_out, 0);
        hold = 1'b0;
        respond_byte(3, lo);
        respond_ck(a, hi, lo);
        finish_fetch("hold");
        check("hold_tx_count", n_tx - n0, 1);

        // reset mid-transfer (in RX_LO)
        a = 8'($urandom);
        accept(a);
        wait_tx_start();
        tick();
        respond_tx(0);
        respond_byte(0, 8'($urandom));
        #2 reset = 1'b0;
        #1;
        check("mid_rst_tx_start", tx_start_out, 0);
        check("mid_rst_tx_data", tx_data_out, 0);
        check("mid_rst_instr", instruction_out, 0);
        check("mid_rst_done", done_out, 0);
        check("mid_rst_busy", busy_out, 0);
        check("mid_rst_error", error_out, 0);
        exp_instr = 16'h0000;
        tick();
        reset = 1'b1;
        tick();
        fetch(8'($urandom), 8'($urandom), 8'($urandom), "after_rst");

`ifdef FETCH_CHECKSUM_EN
        // wrong checksum forces a retry, correct one completes
        n0 = n_tx;
        accept(8'h10);
        wait_tx_start();
        tick();
        respond_tx(0);
        respond_byte(0, 8'h12);
        respond_byte(0, 8'h34);
        respond_byte(0, 8'h00);
        check("ck_bad_retry", tx_start_out, 1);
        check("ck_bad_tx_data", tx_data_out, 8'h10);
        check("ck_bad_instr", instruction_out, exp_instr);
        tick();
        exp_q.push_back(16'h1234);
        respond_tx(0);
        respond_byte(0, 8'h12);
        respond_byte(0, 8'h34);
        respond_byte(0, 8'h36);
        finish_fetch("ck_good");
        check("ck_tx_count", n_tx - n0, 2);
`endif

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_instr_fetcher.md
Name: uart_instr_fetcher

Overview:
- Upstream instruction-fetch stage for the bitty control FSM.
- On a start pulse it sends the PC address byte over the shared UART and receives a 16-bit instruction as two bytes, high byte first.
- It presents the instruction with a one-cycle done pulse.
- Adds a per-byte timeout with bounded retry, and a hold input so the UART can be lent to bitty for load/store traffic.

Parameters:
- TIMEOUT_CYCLES, 20000, cycles allowed between tx_done/rx byte events before a retry (must be >= 2).
- MAX_RETRY, 3, retries after the first attempt before entering error.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- hold  in  1  1 = UART lent to another master; blocks start acceptance and byte capture
- address  in  8  PC value to fetch
- tx_done  in  1  UART transmit-complete pulse
- rx_done  in  1  UART byte-received pulse
- rx_data  in  8  received byte, valid when rx_done=1
- tx_start_out  out  1  one-cycle UART transmit request
- tx_data_out  out  8  byte to transmit
- instruction_out  out  16  last successfully fetched instruction
- done_out  out  1  one-cycle pulse when instruction_out is updated
- busy_out  out  1  high in every state except IDLE and ERROR
- error_out  out  1  sticky retry-exhausted flag

Behaviour:
- Reset (reset=0, asynchronous) values:
  - state=IDLE.
  - All outputs 0, including instruction_out=16'h0000.
  - Retry counter and timeout counter 0.
- States and transitions:
  - IDLE: start=1 and hold=0 -> latch address into addr_q, retry=0 -> SEND.
  - SEND: tx_start_out=1 for exactly this cycle, tx_data_out=addr_q -> WAIT_TX.
  - WAIT_TX: tx_done=1 -> RX_HI.
  - RX_HI: rx_done=1 and hold=0 -> capture hi_q=rx_data -> RX_LO.
  - RX_LO: rx_done=1 and hold=0 -> capture lo_q=rx_data -> DONE.
  - DONE: instruction_out<={hi_q,lo_q}, done_out=1 for one cycle -> IDLE.
  - ERROR: error_out=1. start=1 and hold=0 clears error_out, latches address, retry=0 -> SEND.
- Output timing:
  - tx_data_out holds addr_q from SEND until the next SEND.
  - Latency from accepted start to done_out = 3 + tx time + 2 byte times; minimum 5 cycles with back-to-back events.
- Timeout:
  - Counter runs in WAIT_TX, RX_HI and RX_LO. It clears on state entry and on each accepted byte.
  - Counter frozen while hold=1.
  - On reaching TIMEOUT_CYCLES-1 without the awaited event:
    - retry<MAX_RETRY -> retry+1, discard partial bytes -> SEND.
    - retry==MAX_RETRY -> ERROR.
- Boundary and priority rules:
  - Awaited event and timeout in the same cycle: the event wins.
  - rx_done in IDLE, SEND, WAIT_TX, DONE or ERROR: ignored, with no data capture.
  - start while busy: ignored, with no queuing.
  - hold=1 in IDLE: start ignored, even if pulsed.
  - hold=1 mid-transfer: the state is retained and bytes are ignored; the transfer resumes when hold returns to 0.
  - Reset mid-transfer: immediate return to IDLE; a partial instruction is never exposed.
  - instruction_out changes only in DONE and is held across retries and ERROR.
  - address changes after acceptance have no effect on the current fetch.

Optional Feature:
- Macro: FETCH_CHECKSUM_EN.
- Defined:
  - An extra state RX_CK follows RX_LO and receives a third byte.
  - If byte == hi_q ^ lo_q ^ addr_q -> DONE.
  - Otherwise it is treated as a timeout (retry or ERROR).
  - RX_CK is subject to the same timeout and hold rules.
- Undefined: RX_LO -> DONE directly; no third byte is expected.

Decomposition:
- Package fetch_pkg contains:
  - state encoding: IDLE, SEND, WAIT_TX, RX_HI, RX_LO, RX_CK, DONE, ERROR (4-bit localparams).
  - default TIMEOUT_CYCLES and MAX_RETRY.
  - checksum helper function.
- One sub-module, fetch_timeout_ctr: clear, enable (stage active and !hold), expired output. Its width is $clog2(TIMEOUT_CYCLES).

Test Plan:
- Nominal fetch:
  - Stimulus: address=8'h05, start pulse; bench returns tx_done, then bytes 8'hA1, 8'h23.
  - Required: tx_data_out=8'h05 with a single tx_start_out pulse; instruction_out=16'hA123; one done_out pulse; busy_out=0 afterwards.
- Timeout and retry:
  - Stimulus: TIMEOUT_CYCLES=16, no rx bytes for the first attempt, then a normal response.
  - Required: a second tx_start_out exactly 16 cycles after RX_HI entry; final instruction_out correct; error_out=0.
- Retry exhausted:
  - Stimulus: MAX_RETRY=2, bench never responds.
  - Required: 3 tx_start_out pulses, then error_out=1 and busy_out=0; instruction_out unchanged.
  - Then a new start: error_out clears and the fetch succeeds.
- Hold mid-transfer:
  - Stimulus: assert hold after the high byte for 50 cycles with TIMEOUT_CYCLES=16, injecting a stray rx_done=8'hFF during hold; release and send the low byte.
  - Required: no retry; stray byte ignored; correct instruction_out.
- Reset mid-transfer:
  - Stimulus: drop reset in RX_LO.
  - Required: all outputs 0 asynchronously; after release, a start is accepted normally.
- Checksum (FETCH_CHECKSUM_EN defined):
  - Stimulus: address=8'h10, bytes 8'h12, 8'h34, checksum 8'h00.
  - Required: retry, because the correct value is 8'h36.
  - Next response with checksum 8'h36: done_out pulse, instruction_out=16'h1234.
